// File: rtl/fifo_multiport_pkg.sv
`default_nettype none
// ============================================================================
// fifo_multiport_pkg : width helpers and thermometer-check macro for the FIFO
// Rev 1.0
// ============================================================================
`ifndef FIFO_MULTIPORT_ASSERT_THERMO
// A vector is a thermometer code when no set bit sits above a clear bit.
`define FIFO_MULTIPORT_ASSERT_THERMO(CLK, RSTN, SIG) \
   assert property (@(posedge CLK) disable iff (!(RSTN)) ((((SIG) >> 1) & ~(SIG)) == '0))
`endif

package fifo_multiport_pkg;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_multiport_if.sv
`default_nettype none
// ============================================================================
// fifo_multiport_if : multi-lane push/pop bus with occupancy report
// Rev 1.0
// ============================================================================
interface fifo_multiport_if #(
   parameter int DW     = 64,
   parameter int DEPTH  = 8,
   parameter int PUSH_W = 2,
   parameter int POP_W  = 2
);
   import fifo_multiport_pkg::*;

   localparam int CNT_W = cnt_width(DEPTH);

   logic                  valid_flush;
   logic [PUSH_W*DW-1:0]  push_data;
   logic [PUSH_W-1:0]     push_valid;
   logic [PUSH_W-1:0]     push_ready;
   logic [POP_W*DW-1:0]   pop_data;
   logic [POP_W-1:0]      pop_valid;
   logic [POP_W-1:0]      pop;
   logic [CNT_W-1:0]      occupancy;
   logic [CNT_W-1:0]      free_slots;

   modport master (
      output valid_flush, push_data, push_valid, pop,
      input  push_ready, pop_data, pop_valid, occupancy, free_slots
   );

   modport slave (
      input  valid_flush, push_data, push_valid, pop,
      output push_ready, pop_data, pop_valid, occupancy, free_slots
   );

endinterface
`default_nettype wire

// File: rtl/fifo_multiport_and_or_mux.sv
`default_nettype none
// ============================================================================
// fifo_multiport_and_or_mux : one-hot select of N words via AND-OR reduction
// Rev 1.0
// ============================================================================
module fifo_multiport_and_or_mux #(
   parameter int N  = 8,
   parameter int DW = 64
) (
   input  wire  [N-1:0]    sel_i,
   input  wire  [N*DW-1:0] data_i,
   output logic [DW-1:0]   data_o
);

   always_comb begin
      data_o = '0;
      for (int k = 0; k < N; k++) begin
         data_o = data_o | (data_i[k*DW +: DW] & {DW{sel_i[k]}});
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_multiport.sv
`default_nettype none
// ============================================================================
// fifo_multiport : in-order FIFO taking PUSH_W and delivering POP_W entries/cycle
// Rev 1.0
// ============================================================================
module fifo_multiport
   import fifo_multiport_pkg::*;
#(
   parameter int DW     = 64,
   parameter int DEPTH  = 8,
   parameter int PUSH_W = 2,
   parameter int POP_W  = 2
) (
   input  wire             clk,
   input  wire             rst_n,
   fifo_multiport_if.slave bus_if
);
   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   typedef logic [PTR_W-1:0] fifo_ptr_t;
   typedef logic [CNT_W-1:0] fifo_cnt_t;
   typedef logic [DEPTH-1:0] onehot_t;

   logic [DW-1:0]       mem_q [DEPTH];
   logic [DEPTH*DW-1:0] mem_flat;
   fifo_ptr_t           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   fifo_cnt_t           occ_q, occ_d, free_cnt, n_push, n_pop;
   logic [PUSH_W-1:0]   push_ready, push_take;
   logic [POP_W-1:0]    pop_valid, pop_take;
   logic                push_run, pop_run;
   onehot_t             wr_sel [PUSH_W];
   logic [DW-1:0]       rd_lane [POP_W];

   // Ready/valid come from the registered count only, so pop never feeds push.
   always_comb begin
      free_cnt = fifo_cnt_t'(DEPTH) - occ_q;
      push_run = 1'b1;
      n_push   = '0;
      for (int i = 0; i < PUSH_W; i++) begin
         push_ready[i] = fifo_cnt_t'(i) < free_cnt;
         push_run      = push_run & bus_if.push_valid[i];
         push_take[i]  = push_run & push_ready[i];
         n_push        = n_push + fifo_cnt_t'(push_take[i]);
      end
   end

   always_comb begin
      pop_run = 1'b1;
      n_pop   = '0;
      for (int j = 0; j < POP_W; j++) begin
         pop_valid[j] = fifo_cnt_t'(j) < occ_q;
         pop_run      = pop_run & bus_if.pop[j];
         pop_take[j]  = pop_run & pop_valid[j];
         n_pop        = n_pop + fifo_cnt_t'(pop_take[j]);
      end
   end

   always_comb begin
      if (bus_if.valid_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + fifo_ptr_t'(n_push);
         rd_ptr_d = rd_ptr_q + fifo_ptr_t'(n_pop);
         occ_d    = occ_q + n_push - n_pop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   for (genvar i = 0; i < PUSH_W; i++) begin : g_wr_dec
      fifo_ptr_t wr_idx;
      assign wr_idx    = wr_ptr_q + fifo_ptr_t'(i);
      assign wr_sel[i] = (push_take[i] && !bus_if.valid_flush) ? (onehot_t'(1) << wr_idx) : '0;
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         for (int i = 0; i < PUSH_W; i++) begin
            if (wr_sel[i][k]) mem_q[k] <= bus_if.push_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) mem_flat[k*DW +: DW] = mem_q[k];
   end

   for (genvar j = 0; j < POP_W; j++) begin : g_rd_lane
      fifo_ptr_t rd_idx;
      onehot_t   rd_sel;
      assign rd_idx = rd_ptr_q + fifo_ptr_t'(j);
      assign rd_sel = onehot_t'(1) << rd_idx;

      fifo_multiport_and_or_mux #(
         .N  (DEPTH),
         .DW (DW)
      ) u_mux (
         .sel_i  (rd_sel),
         .data_i (mem_flat),
         .data_o (rd_lane[j])
      );
   end

   always_comb begin
      for (int j = 0; j < POP_W; j++) bus_if.pop_data[j*DW +: DW] = rd_lane[j];
   end

   assign bus_if.push_ready = push_ready;
   assign bus_if.pop_valid  = pop_valid;
   assign bus_if.occupancy  = occ_q;
   assign bus_if.free_slots = free_cnt;

   `FIFO_MULTIPORT_ASSERT_THERMO(clk, rst_n, bus_if.push_valid);
   `FIFO_MULTIPORT_ASSERT_THERMO(clk, rst_n, bus_if.pop);
   assert property (@(posedge clk) disable iff (!rst_n) ((bus_if.pop & ~pop_valid) == '0));

endmodule
`default_nettype wire
